gpu_rasterizer: RTL and testbench

//  Consumer end of the CPU->GPU draw-op FIFO. Pops one gpu_op_t at a time and walks its

---
 rtl/gpu_rasterizer_pkg.sv | 34 +++
 rtl/gpu_rect_walker.sv | 139 +++++++++++++
 rtl/gpu_rasterizer.sv | 122 ++++++++++++
 tb/tb_gpu_rasterizer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rasterizer_pkg.sv
// Shared types and constants for the GPU rasterizer slice.
//   gpu_op_t   : one draw op as popped from the CPU->GPU FIFO
//   asset word : 2 bits {opaque, color}
//   ST_*       : rasterizer FSM encodings (also visible on dbg_state)
//   scale_mask : low-bit mask selecting the sub-texel position for a 2**scale upscale
package gpu_rasterizer_pkg;

  localparam int GPU_ASSET_AW = 16;

  typedef struct packed {
    logic [10:0]             x;
    logic [10:0]             y;
    logic [10:0]             width;
    logic [10:0]             height;
    logic                    color;
    logic                    mem_en;
    logic [GPU_ASSET_AW-1:0] mem_addr;
    logic [1:0]              scale;
  } gpu_op_t;

  localparam int ASSET_OPAQUE_BIT = 1;
  localparam int ASSET_COLOR_BIT  = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  function automatic logic [10:0] scale_mask(input logic [1:0] scale);
    return (11'd1 << scale) - 11'd1;
  endfunction

endpackage

// File: rtl/gpu_rect_walker.sv
// Row-major walker over one draw-op rectangle.
//   load        : capture op geometry, position on pixel (0,0)
//   step        : advance to the next pixel (cx first, then cy)
//   fb_addr     : framebuffer address of the current pixel
//   asset_addr  : asset address of the current pixel for a 2**scale blit
//   clip        : current pixel lies outside the screen
//   last        : current pixel is (width-1, height-1)
// All addresses are maintained incrementally; the only multiply is the
// constant HOR factor applied once at load time.
module gpu_rect_walker
  import gpu_rasterizer_pkg::*;
#(
  parameter int HOR = 640,
  parameter int VER = 480,
  parameter int AW  = 16,
  parameter int FBW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          load,
  input  logic          step,
  input  logic [10:0]   op_x,
  input  logic [10:0]   op_y,
  input  logic [10:0]   op_w,
  input  logic [10:0]   op_h,
  input  logic [1:0]    op_scale,
  input  logic [AW-1:0] op_mem_addr,
  output logic [FBW-1:0] fb_addr,
  output logic [AW-1:0] asset_addr,
  output logic          clip,
  output logic          last
);

  logic [10:0]    cx_q, cx_d, cy_q, cy_d, w_q, w_d, h_q, h_d, sw_q, sw_d;
  logic [11:0]    x_q, x_d, y_q, y_d, x0_q, x0_d;
  logic [1:0]     scale_q, scale_d;
  logic [FBW-1:0] fb_row_q, fb_row_d, fb_pix_q, fb_pix_d;
  logic [AW-1:0]  a_row_q, a_row_d, a_pix_q, a_pix_d;
  logic [10:0]    mask, cx_inc, cy_inc;
  logic           row_end;

  always_comb begin
    mask     = scale_mask(scale_q);
    cx_inc   = cx_q + 11'd1;
    cy_inc   = cy_q + 11'd1;
    row_end  = (cx_q == w_q - 11'd1);
    cx_d     = cx_q;
    cy_d     = cy_q;
    w_d      = w_q;
    h_d      = h_q;
    sw_d     = sw_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    scale_d  = scale_q;
    fb_row_d = fb_row_q;
    fb_pix_d = fb_pix_q;
    a_row_d  = a_row_q;
    a_pix_d  = a_pix_q;
    if (load) begin
      cx_d     = 11'd0;
      cy_d     = 11'd0;
      w_d      = op_w;
      h_d      = op_h;
      scale_d  = op_scale;
      sw_d     = op_w >> op_scale;
      x_d      = {1'b0, op_x};
      x0_d     = {1'b0, op_x};
      y_d      = {1'b0, op_y};
      fb_row_d = FBW'(32'(op_y) * 32'(HOR) + 32'(op_x));
      fb_pix_d = FBW'(32'(op_y) * 32'(HOR) + 32'(op_x));
      a_row_d  = op_mem_addr;
      a_pix_d  = op_mem_addr;
    end else if (step) begin
      if (row_end) begin
        cx_d     = 11'd0;
        cy_d     = cy_inc;
        x_d      = x0_q;
        y_d      = y_q + 12'd1;
        fb_row_d = fb_row_q + FBW'(HOR);
        fb_pix_d = fb_row_q + FBW'(HOR);
        // A new source row starts only when cy crosses a 2**scale boundary.
        if ((cy_inc & mask) == 11'd0) begin
          a_row_d = a_row_q + AW'(sw_q);
          a_pix_d = a_row_q + AW'(sw_q);
        end else begin
          a_pix_d = a_row_q;
        end
      end else begin
        cx_d     = cx_inc;
        x_d      = x_q + 12'd1;
        fb_pix_d = fb_pix_q + FBW'(1);
        if ((cx_inc & mask) == 11'd0) begin
          a_pix_d = a_pix_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q     <= '0;
      cy_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      sw_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      scale_q  <= '0;
      fb_row_q <= '0;
      fb_pix_q <= '0;
      a_row_q  <= '0;
      a_pix_q  <= '0;
    end else if (ce) begin
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      w_q      <= w_d;
      h_q      <= h_d;
      sw_q     <= sw_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      scale_q  <= scale_d;
      fb_row_q <= fb_row_d;
      fb_pix_q <= fb_pix_d;
      a_row_q  <= a_row_d;
      a_pix_q  <= a_pix_d;
    end
  end

  // 12-bit screen coordinates: x+width cannot wrap back into the screen.
  assign clip       = (x_q >= 12'(HOR)) || (y_q >= 12'(VER));
  assign last       = row_end && (cy_q == h_q - 11'd1);
  assign fb_addr    = fb_pix_q;
  assign asset_addr = a_pix_q;

endmodule

// File: rtl/gpu_rasterizer.sv
// Consumer end of the CPU->GPU draw-op FIFO: pops one op at a time and writes
// its rectangle, one pixel per cycle, into the back framebuffer (solid fill or
// upscaled asset blit).
//   clk, rst, ce          : clock, sync active-high reset, clock enable
//   op, op_rd_en, op_empty: FIFO read port
//   asset_addr, asset_data: asset memory read port, 1-cycle latency
//   fb_wr_en/addr/data    : framebuffer write port
//   idle                  : nothing queued and nothing in flight
//   dbg_state             : current FSM state
// Handshakes: op_rd_en is a one-cycle pop (POP state); op is valid the next
// cycle (LATCH). fb_wr_en is a one-cycle strobe per pixel with no backpressure.
// While ce is low every register and every output holds.
module gpu_rasterizer
  import gpu_rasterizer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int ASSET_ADDR_WIDTH  = GPU_ASSET_AW,
  parameter int FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  gpu_op_t                     op,
  output logic                        op_rd_en,
  input  logic                        op_empty,
  output logic [ASSET_ADDR_WIDTH-1:0] asset_addr,
  input  logic [1:0]                  asset_data,
  output logic                        fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0]    fb_addr,
  output logic                        fb_data,
  output logic                        idle,
  output logic [2:0]                  dbg_state
);

  logic [2:0]               state_q, state_d;
  logic                     color_q, color_d;
  logic                     blit_q, blit_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [FB_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;

  logic                     walk_load, walk_step, walk_clip, walk_last;
  logic [FB_ADDR_WIDTH-1:0] walk_fb_addr;

  gpu_rect_walker #(
    .HOR (HOR_ACTIVE_PIXELS),
    .VER (VER_ACTIVE_PIXELS),
    .AW  (ASSET_ADDR_WIDTH),
    .FBW (FB_ADDR_WIDTH)
  ) u_walker (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .load        (walk_load),
    .step        (walk_step),
    .op_x        (op.x),
    .op_y        (op.y),
    .op_w        (op.width),
    .op_h        (op.height),
    .op_scale    (op.scale),
    .op_mem_addr (ASSET_ADDR_WIDTH'(op.mem_addr)),
    .fb_addr     (walk_fb_addr),
    .asset_addr  (asset_addr),
    .clip        (walk_clip),
    .last        (walk_last)
  );

  assign walk_load = (state_q == ST_LATCH);
  assign walk_step = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    color_d    = color_q;
    blit_d     = blit_q;
    s1_valid_d = 1'b0;
    s1_addr_d  = s1_addr_q;
    case (state_q)
      ST_IDLE:  if (!op_empty) state_d = ST_POP;
      ST_POP:   state_d = ST_LATCH;
      ST_LATCH: begin
        color_d = op.color;
        blit_d  = op.mem_en;
        if (op.width == 11'd0 || op.height == 11'd0) state_d = ST_IDLE;
        else                                           state_d = ST_RUN;
      end
      ST_RUN: begin
        // Stage 0: clipped pixels still take their cycle but never write.
        s1_valid_d = !walk_clip;
        s1_addr_d  = walk_fb_addr;
        if (walk_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      color_q    <= 1'b0;
      blit_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      color_q    <= color_d;
      blit_q     <= blit_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
    end
  end

  // Stage 1: asset_data is the read issued by stage 0 one cycle earlier, so it
  // is used directly here; transparent texels drop their write.
  assign fb_wr_en  = s1_valid_q && (!blit_q || asset_data[ASSET_OPAQUE_BIT]);
  assign fb_data   = s1_valid_q && (blit_q ? asset_data[ASSET_COLOR_BIT] : color_q);
  assign fb_addr   = s1_addr_q;
  assign op_rd_en  = (state_q == ST_POP);
  assign idle      = (state_q == ST_IDLE) && op_empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gpu_rasterizer.sv
// Self-checking bench for gpu_rasterizer on a 16x8 screen. A FIFO model feeds
// ops, an asset-memory model answers reads with 1-cycle latency, and a monitor
// records every framebuffer write. Expected writes come from a per-op model
// that walks the rectangle with plain arithmetic.
module tb_gpu_rasterizer;
  import gpu_rasterizer_pkg::*;

  localparam int HOR = 16;
  localparam int VER = 8;
  localparam int AW  = 16;
  localparam int FBW = $clog2(HOR * VER);

  logic           clk, rst, ce;
  gpu_op_t        op;
  logic           op_rd_en, op_empty;
  logic [AW-1:0]  asset_addr;
  logic [1:0]     asset_data;
  logic           fb_wr_en, fb_data, idle;
  logic [FBW-1:0] fb_addr;
  logic [2:0]     dbg_state;

  gpu_rasterizer #(
    .HOR_ACTIVE_PIXELS (HOR),
    .VER_ACTIVE_PIXELS (VER),
    .ASSET_ADDR_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .op         (op),
    .op_rd_en   (op_rd_en),
    .op_empty   (op_empty),
    .asset_addr (asset_addr),
    .asset_data (asset_data),
    .fb_wr_en   (fb_wr_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .idle       (idle),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO and asset memory models ----------------
  gpu_op_t    fifo_mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [1:0] asset_mem [0:1023];

  assign op_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (ce && op_rd_en && rd_ptr != wr_ptr) begin
      op     <= fifo_mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (ce) asset_data <= (asset_addr < 16'd1024) ? asset_mem[asset_addr[9:0]] : 2'b00;
  end

  // ---------------- monitor ----------------
  logic [FBW:0] obs_q[$];
  int           obs_cyc_q[$];
  int           pop_cyc = 0;
  int           pop_cnt = 0;
  int           flush_cyc = 0;

  always @(negedge clk) begin
    if (ce && fb_wr_en) begin
      obs_q.push_back({fb_addr, fb_data});
      obs_cyc_q.push_back(cyc);
    end
    if (ce && op_rd_en) begin
      pop_cyc = cyc;
      pop_cnt = pop_cnt + 1;
    end
    if (ce && dbg_state == ST_FLUSH) flush_cyc = cyc;
  end

  // ---------------- scoreboard / model ----------------
  logic [FBW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_op(input gpu_op_t o);
    int px, py, sw, a;
    logic [1:0] word;
    for (int cy = 0; cy < int'(o.height); cy++) begin
      for (int cx = 0; cx < int'(o.width); cx++) begin
        px = int'(o.x) + cx;
        py = int'(o.y) + cy;
        if (px < HOR && py < VER) begin
          if (!o.mem_en) begin
            exp_q.push_back({FBW'(py * HOR + px), o.color});
          end else begin
            sw   = int'(o.width) >> o.scale;
            a    = int'(o.mem_addr) + (cy >> o.scale) * sw + (cx >> o.scale);
            word = asset_mem[a % 1024];
            if (word[1]) exp_q.push_back({FBW'(py * HOR + px), word[0]});
          end
        end
      end
    end
  endfunction

  function automatic gpu_op_t mk_op(input int x, input int y, input int w, input int h,
                                    input bit color, input bit mem_en, input int mem_addr,
                                    input int scale);
    gpu_op_t o;
    o.x        = 11'(x);
    o.y        = 11'(y);
    o.width    = 11'(w);
    o.height   = 11'(h);
    o.color    = color;
    o.mem_en   = mem_en;
    o.mem_addr = GPU_ASSET_AW'(mem_addr);
    o.scale    = 2'(scale);
    return o;
  endfunction

  // ---------------- drivers ----------------
  task automatic push_op(input gpu_op_t o);
    fifo_mem[wr_ptr % 16] = o;
    wr_ptr = wr_ptr + 1;
    model_op(o);
  endtask

  task automatic wait_idle(input int budget, input bit rand_ce, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!ok) begin
        if (rand_ce) ce = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        ok = idle;
      end
    end
    ce = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (op_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_op_rd_en: got %b expected 0", op_rd_en); end
    n_checks++; if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_fb_wr_en: got %b expected 0", fb_wr_en); end
    n_checks++; if (fb_addr !== '0) begin n_fail++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
    n_checks++; if (fb_data !== 1'b0) begin n_fail++; $display("FAIL reset_fb_data: got %b expected 0", fb_data); end
    n_checks++; if (asset_addr !== '0) begin n_fail++; $display("FAIL reset_asset_addr: got %0d expected 0", asset_addr); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
  endtask

  task automatic test_fill();
    int s0;
    bit ok;
    exp_q.delete();
    s0 = obs_q.size();
    ce = 1'b0;
    push_op(mk_op(3, 5, 4, 2, 1'b1, 1'b0, 0, 0));
    @(negedge clk);
    // Frozen in IDLE with a queued op: not idle and no pop.
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL fill_idle_queued: got %b expected 0", idle); end
    n_checks++; if (op_rd_en !== 1'b0) begin n_fail++; $display("FAIL fill_pop_frozen: got %b expected 0", op_rd_en); end
    ce = 1'b1;
    wait_idle(200, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_timeout: got busy expected idle"); end
    n_checks++;
    if (obs_q.size() - s0 !== exp_q.size()) begin
      n_fail++; $display("FAIL fill_count: got %0d expected %0d", obs_q.size() - s0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[s0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL fill_pix%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, obs_q[s0+i][FBW:1], obs_q[s0+i][0], exp_q[i][FBW:1], exp_q[i][0]);
        end
      end
      n_checks++;
      if (obs_cyc_q[s0] - pop_cyc !== 3) begin
        n_fail++; $display("FAIL fill_first_latency: got %0d expected 3", obs_cyc_q[s0] - pop_cyc);
      end
    end
    n_checks++; if (flush_cyc - pop_cyc !== 4 * 2 + 2) begin n_fail++; $display("FAIL fill_flush_time: got %0d expected %0d", flush_cyc - pop_cyc, 10); end
  endtask

  task automatic test_blit();
    int s0;
    bit ok;
    exp_q.delete();
    s0 = obs_q.size();
    for (int a = 10; a < 14; a++) asset_mem[a] = {1'b1, 1'($urandom_range(0, 1))};
    push_op(mk_op(0, 0, 4, 4, 1'b0, 1'b1, 10, 1));
    wait_idle(200, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL blit_timeout: got busy expected idle"); end
    n_checks++;
    if (obs_q.size() - s0 !== 16) begin
      n_fail++; $display("FAIL blit_count: got %0d expected 16", obs_q.size() - s0);
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[s0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL blit_pix%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, obs_q[s0+i][FBW:1], obs_q[s0+i][0], exp_q[i][FBW:1], exp_q[i][0]);
        end
      end
    end
  endtask

  task automatic test_clip();
    int s0;
    bit ok;
    exp_q.delete();
    s0 = obs_q.size();
    push_op(mk_op(14, 7, 4, 2, 1'b1, 1'b0, 0, 0));
    wait_idle(200, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clip_timeout: got busy expected idle"); end
    n_checks++;
    if (obs_q.size() - s0 !== exp_q.size()) begin
      n_fail++; $display("FAIL clip_count: got %0d expected %0d", obs_q.size() - s0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[s0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL clip_pix%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, obs_q[s0+i][FBW:1], obs_q[s0+i][0], exp_q[i][FBW:1], exp_q[i][0]);
        end
      end
    end
    n_checks++; if (flush_cyc - pop_cyc !== 10) begin n_fail++; $display("FAIL clip_flush_time: got %0d expected 10", flush_cyc - pop_cyc); end
  endtask

  task automatic test_back_to_back();
    int s0, p0;
    bit ok;
    exp_q.delete();
    s0 = obs_q.size();
    p0 = pop_cnt;
    push_op(mk_op(2, 2, 0, 3, 1'b1, 1'b0, 0, 0));
    push_op(mk_op(1, 1, 3, 1, 1'b1, 1'b0, 0, 0));
    wait_idle(200, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got busy expected idle"); end
    n_checks++; if (pop_cnt - p0 !== 2) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 2", pop_cnt - p0); end
    n_checks++;
    if (obs_q.size() - s0 !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size() - s0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[s0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_pix%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, obs_q[s0+i][FBW:1], obs_q[s0+i][0], exp_q[i][FBW:1], exp_q[i][0]);
        end
      end
    end
  endtask

  task automatic test_transparent();
    int s0;
    bit ok;
    exp_q.delete();
    s0 = obs_q.size();
    for (int a = 40; a < 58; a++) asset_mem[a] = 2'($urandom_range(0, 3));
    asset_mem[41] = 2'b00;
    asset_mem[42] = 2'b11;
    push_op(mk_op(2, 1, 6, 3, 1'b0, 1'b1, 40, 0));
    wait_idle(200, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL transp_timeout: got busy expected idle"); end
    n_checks++;
    if (obs_q.size() - s0 !== exp_q.size()) begin
      n_fail++; $display("FAIL transp_count: got %0d expected %0d", obs_q.size() - s0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[s0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL transp_pix%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, obs_q[s0+i][FBW:1], obs_q[s0+i][0], exp_q[i][FBW:1], exp_q[i][0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int s0;
    exp_q.delete();
    push_op(mk_op(0, 0, 16, 8, 1'b1, 1'b0, 0, 0));
    repeat (20) @(negedge clk);
    n_checks++; if (fb_wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_writing: got %b expected 1", fb_wr_en); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_en: got %b expected 0", fb_wr_en); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 1", idle); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    s0 = obs_q.size();
    repeat (6) @(negedge clk);
    n_checks++; if (obs_q.size() - s0 !== 0) begin n_fail++; $display("FAIL rstmid_no_writes: got %0d expected 0", obs_q.size() - s0); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_after: got %b expected 1", idle); end
  endtask

  task automatic test_random();
    int s0;
    bit ok;
    exp_q.delete();
    s0 = obs_q.size();
    for (int a = 0; a < 1024; a++) asset_mem[a] = 2'($urandom_range(0, 3));
    for (int k = 0; k < 12; k++) begin
      push_op(mk_op($urandom_range(0, 19), $urandom_range(0, 10), $urandom_range(0, 6),
                    $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 500), $urandom_range(0, 2)));
    end
    wait_idle(5000, 1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got busy expected idle"); end
    n_checks++;
    if (obs_q.size() - s0 !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size() - s0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[s0+i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_pix%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, obs_q[s0+i][FBW:1], obs_q[s0+i][0], exp_q[i][FBW:1], exp_q[i][0]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int a = 0; a < 1024; a++) asset_mem[a] = 2'b00;
    test_reset();
    test_fill();
    test_blit();
    test_clip();
    test_back_to_back();
    test_transparent();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
